game_progress_ctl: RTL and testbench

Gameplay progress tracker feeding the main game state machine. It counts target hits, lives and the per-level countdown while the game state is GAME. It raises held `next_lvl` / `fail` flags when a level is completed or lost, and it maintains the level number used for the FINISH decision. All counters are exported to the text/HUD overlay.

---
 rtl/game_progress_ctl.sv | 140 ++++++++++++++
 tb/tb_game_progress_ctl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/game_progress_ctl.sv
// -----------------------------------------------------------------------------
// game_progress_ctl
//
// Tracks gameplay progress for the main game state machine: target hits on the
// current level, remaining lives, the per-level frame countdown and the level
// number. Raises held level-complete (next_lvl) and game-lost (fail) flags that
// the main FSM reacts to; all counters also feed the HUD overlay.
//
// Ports:
//   clk        in   1   system clock
//   rst_n      in   1   asynchronous active-low reset
//   game_state in   3   main FSM state (START=0, NEXT_LEVEL=1, FAIL=2,
//                       FINISH=3, GAME=4)
//   frame_tick in   1   one-cycle pulse per video frame
//   target_hit in   1   one-cycle pulse per target hit
//   ball_lost  in   1   one-cycle pulse per ball lost
//   next_lvl   out  1   level completed, held while game_state stays GAME
//   fail       out  1   game lost, held while game_state stays GAME
//   lvl        out 13   current level number (starts at 1, wraps)
//   hits       out  8   hits on the current level (saturates at 255)
//   lives      out  2   remaining lives
//   time_left  out 12   frames remaining on the current level
// -----------------------------------------------------------------------------
module game_progress_ctl #(
    parameter int HITS_BASE  = 4,
    parameter int HITS_STEP  = 2,
    parameter int TIME_LIMIT = 1800,
    parameter int LIVES      = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  game_state,
    input  logic        frame_tick,
    input  logic        target_hit,
    input  logic        ball_lost,
    output logic        next_lvl,
    output logic        fail,
    output logic [12:0] lvl,
    output logic [7:0]  hits,
    output logic [1:0]  lives,
    output logic [11:0] time_left
);

    localparam logic [2:0] ST_START = 3'd0;
    localparam logic [2:0] ST_GAME  = 3'd4;

    logic [12:0] lvl_q,  lvl_d;
    logic [7:0]  hits_q, hits_d;
    logic [1:0]  lives_q, lives_d;
    logic [11:0] time_q, time_d;
    logic        next_lvl_q, next_lvl_d;
    logic        fail_q, fail_d;

    // Hit target for the current level, deliberately evaluated at 8 bits;
    // only the low byte of (lvl - 1) can influence an 8-bit result.
    logic [7:0] lvl_m1_lo;
    logic [7:0] target;
    logic [8:0] hits_plus1;
    logic       hit_goal;
    logic       lives_last;
    logic       time_last;
    logic       fail_evt;

    assign lvl_m1_lo  = lvl_q[7:0] - 8'd1;
    assign target     = 8'(HITS_BASE) + 8'(HITS_STEP) * lvl_m1_lo;
    // 9-bit increment so the goal test still works when hits is saturated.
    assign hits_plus1 = {1'b0, hits_q} + 9'd1;
    assign hit_goal   = target_hit && (hits_plus1 >= {1'b0, target});
    assign lives_last = (lives_q <= 2'd1);
    assign time_last  = (time_q <= 12'd1);
    assign fail_evt   = (ball_lost && lives_last) || (frame_tick && time_last);

    always_comb begin
        lvl_d      = lvl_q;
        hits_d     = hits_q;
        lives_d    = lives_q;
        time_d     = time_q;
        next_lvl_d = next_lvl_q;
        fail_d     = fail_q;

        if (game_state == ST_START) begin
            lvl_d      = 13'd1;
            lives_d    = 2'(LIVES);
            hits_d     = 8'd0;
            time_d     = 12'(TIME_LIMIT);
            next_lvl_d = 1'b0;
            fail_d     = 1'b0;
        end else if (game_state != ST_GAME) begin
            // Between-level states (and unknown codes) reload the per-level
            // counters; level and lives carry over.
            hits_d     = 8'd0;
            time_d     = 12'(TIME_LIMIT);
            next_lvl_d = 1'b0;
            fail_d     = 1'b0;
        end else if (!next_lvl_q && !fail_q) begin
            if (target_hit && hits_q != 8'hFF) begin
                hits_d = hits_q + 8'd1;
            end
            if (ball_lost && lives_q != 2'd0) begin
                lives_d = lives_q - 2'd1;
            end
            if (frame_tick && time_q != 12'd0) begin
                time_d = time_q - 12'd1;
            end
            // Losing wins over completing when both happen in one cycle.
            if (fail_evt) begin
                fail_d = 1'b1;
            end else if (hit_goal) begin
                next_lvl_d = 1'b1;
                lvl_d      = lvl_q + 13'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q      <= 13'd1;
            hits_q     <= 8'd0;
            lives_q    <= 2'(LIVES);
            time_q     <= 12'(TIME_LIMIT);
            next_lvl_q <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            lvl_q      <= lvl_d;
            hits_q     <= hits_d;
            lives_q    <= lives_d;
            time_q     <= time_d;
            next_lvl_q <= next_lvl_d;
            fail_q     <= fail_d;
        end
    end

    assign next_lvl  = next_lvl_q;
    assign fail      = fail_q;
    assign lvl       = lvl_q;
    assign hits      = hits_q;
    assign lives     = lives_q;
    assign time_left = time_q;

endmodule

// File: tb/tb_game_progress_ctl.sv
module tb_game_progress_ctl;

    localparam int HB = 4;
    localparam int HS = 2;
    localparam int TL = 1800;
    localparam int LV = 3;

    localparam logic [2:0] S_START = 3'd0;
    localparam logic [2:0] S_NEXT  = 3'd1;
    localparam logic [2:0] S_FAIL  = 3'd2;
    localparam logic [2:0] S_FIN   = 3'd3;
    localparam logic [2:0] S_GAME  = 3'd4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  game_state = 3'd0;
    logic        frame_tick = 1'b0;
    logic        target_hit = 1'b0;
    logic        ball_lost = 1'b0;
    logic        next_lvl;
    logic        fail;
    logic [12:0] lvl;
    logic [7:0]  hits;
    logic [1:0]  lives;
    logic [11:0] time_left;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state, kept as plain integers.
    int m_lvl, m_hits, m_lives, m_time;
    bit m_nl, m_fail;

    game_progress_ctl #(
        .HITS_BASE (HB),
        .HITS_STEP (HS),
        .TIME_LIMIT(TL),
        .LIVES     (LV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .game_state(game_state),
        .frame_tick(frame_tick),
        .target_hit(target_hit),
        .ball_lost (ball_lost),
        .next_lvl  (next_lvl),
        .fail      (fail),
        .lvl       (lvl),
        .hits      (hits),
        .lives     (lives),
        .time_left (time_left)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".lvl"},       32'(lvl),       32'(m_lvl));
        chk({tag, ".hits"},      32'(hits),      32'(m_hits));
        chk({tag, ".lives"},     32'(lives),     32'(m_lives));
        chk({tag, ".time_left"}, 32'(time_left), 32'(m_time));
        chk({tag, ".next_lvl"},  32'(next_lvl),  32'(m_nl));
        chk({tag, ".fail"},      32'(fail),      32'(m_fail));
    endtask

    function automatic void model_reset();
        m_lvl = 1; m_lives = LV; m_hits = 0; m_time = TL; m_nl = 0; m_fail = 0;
    endfunction

    // One clock's worth of the progress rules, written from the game's point
    // of view: evaluate every rule against the old values, then commit.
    function automatic void model_step(input int gs, input bit th, input bit bl, input bit ft);
        int  tgt;
        bit  lose;
        if (gs == 0) begin
            model_reset();
        end else if (gs != 4) begin
            m_hits = 0; m_time = TL; m_nl = 0; m_fail = 0;
        end else if (!m_nl && !m_fail) begin
            tgt  = (HB + HS * (m_lvl - 1)) & 255;
            lose = (bl && m_lives <= 1) || (ft && m_time <= 1);
            if (lose) m_fail = 1;
            else if (th && (m_hits + 1) >= tgt) begin
                m_nl  = 1;
                m_lvl = (m_lvl + 1) % 8192;
            end
            if (th) m_hits = (m_hits + 1 > 255) ? 255 : m_hits + 1;
            if (bl && m_lives > 0) m_lives = m_lives - 1;
            if (ft && m_time > 0)  m_time = m_time - 1;
        end
    endfunction

    task automatic step(input string tag, input logic [2:0] gs, input bit th, input bit bl, input bit ft);
        game_state = gs;
        target_hit = th;
        ball_lost  = bl;
        frame_tick = ft;
        @(posedge clk);
        model_step(int'(gs), th, bl, ft);
        #1;
        chk_all(tag);
        $display("step %-8s gs=%0d th=%0d bl=%0d ft=%0d -> lvl=%0d hits=%0d lives=%0d time=%0d nl=%0d fail=%0d",
                 tag, gs, th, bl, ft, lvl, hits, lives, time_left, next_lvl, fail);
    endtask

    initial begin
        int need;
        int r;
        logic [2:0] gs;

        // Reset held from time 0.
        model_reset();
        #12;
        chk_all("rst0");
        @(negedge clk);
        rst_n = 1'b1;

        // Mid-level asynchronous reset: hits=3, lives=1.
        step("start", S_START, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("pre_hit", S_GAME, 1, 0, 0);
        for (int i = 0; i < 2; i++) step("pre_bl", S_GAME, 0, 1, 0);
        chk("pre_rst.hits", 32'(hits), 32'd3);
        chk("pre_rst.lives", 32'(lives), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_all("async_rst");
        chk("async_rst.time", 32'(time_left), 32'd1800);
        @(negedge clk);
        rst_n = 1'b1;

        // Level completion on level 1.
        step("start", S_START, 0, 0, 0);
        for (int i = 0; i < 4; i++) step("l1_hit", S_GAME, 1, 0, 0);
        chk("l1_done.nl", 32'(next_lvl), 32'd1);
        chk("l1_done.lvl", 32'(lvl), 32'd2);
        step("hit5", S_GAME, 1, 0, 0);
        chk("hit5.hits", 32'(hits), 32'd4);
        step("nextlvl", S_NEXT, 0, 0, 0);
        chk("nextlvl.lvl", 32'(lvl), 32'd2);

        // Lives exhaustion, then START reload.
        step("start", S_START, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("bl", S_GAME, 0, 1, 0);
        chk("lives0.fail", 32'(fail), 32'd1);
        step("restart", S_START, 0, 0, 0);
        chk("restart.lives", 32'(lives), 32'd3);

        // Timeout boundary.
        step("start", S_START, 0, 0, 0);
        for (int i = 0; i < TL - 1; i++) begin
            game_state = S_GAME; frame_tick = 1; target_hit = 0; ball_lost = 0;
            @(posedge clk);
            model_step(4, 0, 0, 1);
            #1;
            chk_all("tick");
        end
        chk("t1799.time", 32'(time_left), 32'd1);
        chk("t1799.fail", 32'(fail), 32'd0);
        step("tick1800", S_GAME, 0, 0, 1);
        chk("t1800.fail", 32'(fail), 32'd1);
        chk("t1800.time", 32'(time_left), 32'd0);

        // Simultaneous hit and last-life loss.
        step("start", S_START, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("s_hit", S_GAME, 1, 0, 0);
        for (int i = 0; i < 2; i++) step("s_bl", S_GAME, 0, 1, 0);
        step("simul", S_GAME, 1, 1, 0);
        chk("simul.nl", 32'(next_lvl), 32'd0);
        chk("simul.lvl", 32'(lvl), 32'd1);
        chk("simul.hits", 32'(hits), 32'd4);

        // Finish path through three levels, with pulses during NEXT_LEVEL.
        step("start", S_START, 0, 0, 0);
        for (int l = 1; l <= 3; l++) begin
            need = HB + HS * (l - 1);
            for (int i = 0; i < need; i++) step("fin_hit", S_GAME, 1, 0, 0);
            step("fin_nl", S_NEXT, 1, 1, 1);
        end
        chk("finish.lvl", 32'(lvl), 32'd4);

        // Randomized play against the model.
        step("start", S_START, 0, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 80)      gs = S_GAME;
            else if (r < 85) gs = S_NEXT;
            else if (r < 88) gs = S_FAIL;
            else if (r < 90) gs = S_FIN;
            else if (r < 93) gs = 3'(5 + $urandom_range(0, 2));
            else             gs = S_START;
            game_state = gs;
            target_hit = ($urandom_range(0, 9) < 3);
            ball_lost  = ($urandom_range(0, 19) < 1);
            frame_tick = ($urandom_range(0, 9) < 4);
            @(posedge clk);
            model_step(int'(gs), target_hit, ball_lost, frame_tick);
            #1;
            chk_all("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
